// File: rtl/fp_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_op_sequencer_if
// Description : Execute-stage / FP datapath handshake bundle for the FP
//               operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_op_sequencer_if;
  logic       FpValidE;
  logic [2:0] FpOpE;
  logic [4:0] RdE;
  logic       FlushE;
  logic       UnitDone;

  logic       FpStart;
  logic [2:0] FpOpOut;
  logic [4:0] RdF;
  logic       BusyF;
  logic       DoneF;
  logic       RegWriteF;
  logic       ErrorF;
  logic       IllegalF;

  modport master (
    output FpValidE, FpOpE, RdE, FlushE, UnitDone,
    input  FpStart, FpOpOut, RdF, BusyF, DoneF, RegWriteF, ErrorF, IllegalF
  );

  modport slave (
    input  FpValidE, FpOpE, RdE, FlushE, UnitDone,
    output FpStart, FpOpOut, RdF, BusyF, DoneF, RegWriteF, ErrorF, IllegalF
  );
endinterface
`default_nettype wire

// File: rtl/fp_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fp_op_sequencer
// Description : Issues multi-cycle FP ops, tracks fixed/variable completion
//               and drives the BusyF/DoneF stall pair plus writeback control.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_op_sequencer #(
  parameter int LAT_ADD = 3,
  parameter int LAT_MUL = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_op_sequencer_if.slave  bus
);

  localparam logic [1:0] c_stIdle = 2'd0;
  localparam logic [1:0] c_stExec = 2'd1;
  localparam logic [1:0] c_stWait = 2'd2;
  localparam logic [1:0] c_stDone = 2'd3;

  localparam logic [2:0] c_opMul  = 3'b010;
  localparam logic [2:0] c_opDiv  = 3'b011;
  localparam logic [2:0] c_opSqrt = 3'b100;
  localparam logic [2:0] c_opRsv  = 3'b111;

  localparam logic [CNT_W-1:0] c_latAdd    = CNT_W'(LAT_ADD);
  localparam logic [CNT_W-1:0] c_latMul    = CNT_W'(LAT_MUL);
  localparam logic [CNT_W-1:0] c_lastWait  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;

  logic             r_fpStart;
  logic             r_done;
  logic             r_regWrite;
  logic             r_error;
  logic             r_illegal;
  logic [2:0]       r_fpOp;
  logic [4:0]       r_rd;

  logic             w_canIssue;
  logic             w_present;
  logic             w_accept;
  logic             w_illegal;
  logic             w_isVarLat;
  logic [CNT_W-1:0] w_fixLat;
  logic             w_toDone;
  logic             w_abort;

  // A new op may issue from IDLE or in the DONE cycle (back-to-back).
  assign w_canIssue = (r_state == c_stIdle) || (r_state == c_stDone);
  assign w_present  = bus.FpValidE & ~bus.FlushE & w_canIssue;
  assign w_accept   = w_present & (bus.FpOpE != c_opRsv);
  assign w_illegal  = w_present & (bus.FpOpE == c_opRsv);
  assign w_isVarLat = (bus.FpOpE == c_opDiv) || (bus.FpOpE == c_opSqrt);
  assign w_fixLat   = (bus.FpOpE == c_opMul) ? c_latMul : c_latAdd;

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_toDone    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      c_stIdle, c_stDone: begin
        w_stateNext = c_stIdle;
        if (w_accept) begin
          if (w_isVarLat) begin
            w_stateNext = c_stWait;
            w_cntNext   = '0;
          end else begin
            w_stateNext = c_stExec;
            w_cntNext   = w_fixLat;
          end
        end
      end
      c_stExec: begin
        if (r_cnt == c_one) begin
          w_stateNext = c_stDone;
          w_toDone    = 1'b1;
        end else begin
          w_cntNext = r_cnt - c_one;
        end
      end
      c_stWait: begin
        w_cntNext = r_cnt + c_one;
        // Completion takes priority over a timeout landing in the same cycle.
        if (bus.UnitDone) begin
          w_stateNext = c_stDone;
          w_toDone    = 1'b1;
        end else if (r_cnt == c_lastWait) begin
          w_stateNext = c_stDone;
          w_toDone    = 1'b1;
          w_abort     = 1'b1;
        end
      end
      default: begin
        w_stateNext = c_stIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_stIdle;
      r_cnt      <= '0;
      r_fpStart  <= 1'b0;
      r_done     <= 1'b0;
      r_regWrite <= 1'b0;
      r_error    <= 1'b0;
      r_illegal  <= 1'b0;
      r_fpOp     <= 3'b000;
      r_rd       <= 5'd0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_fpStart  <= w_accept;
      r_done     <= w_toDone;
      r_regWrite <= w_toDone & ~w_abort;
      r_error    <= w_toDone & w_abort;
      r_illegal  <= w_illegal;
      if (w_accept) begin
        r_fpOp <= bus.FpOpE;
        r_rd   <= bus.RdE;
      end
    end
  end

  // BusyF stays combinational so the front end stalls in the accept cycle.
  assign bus.BusyF     = rst_n & (w_accept | (r_state == c_stExec) | (r_state == c_stWait));
  assign bus.FpStart   = r_fpStart;
  assign bus.FpOpOut   = r_fpOp;
  assign bus.RdF       = r_rd;
  assign bus.DoneF     = r_done;
  assign bus.RegWriteF = r_regWrite;
  assign bus.ErrorF    = r_error;
  assign bus.IllegalF  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_fp_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_op_sequencer
// Description : Self-checking bench: vector table plus hand sequences for
//               back-to-back issue and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_op_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_op_sequencer_if bus ();

  fp_op_sequencer #(
    .LAT_ADD (3),
    .LAT_MUL (4),
    .TIMEOUT (64),
    .CNT_W   (7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] op;
    logic [4:0] rd;
    logic       regWrite;
    logic       error;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [4:0] rd;
    logic       flush;
    int         udAt;
    int         doneAt;
    logic       err;
    logic       ill;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   nTests = 0;
  int   nFail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkDone(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_done"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rd"}, int'(bus.RdF), int'(e.rd));
      chk({tag, "_op"}, int'(bus.FpOpOut), int'(e.op));
      chk({tag, "_regwrite"}, int'(bus.RegWriteF), int'(e.regWrite));
      chk({tag, "_error"}, int'(bus.ErrorF), int'(e.error));
    end
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_busy"},   int'(bus.BusyF), 0);
    chk({tag, "_start"},  int'(bus.FpStart), 0);
    chk({tag, "_done"},   int'(bus.DoneF), 0);
    chk({tag, "_regwr"},  int'(bus.RegWriteF), 0);
    chk({tag, "_error"},  int'(bus.ErrorF), 0);
    chk({tag, "_ill"},    int'(bus.IllegalF), 0);
    chk({tag, "_rd"},     int'(bus.RdF), 0);
    chk({tag, "_op"},     int'(bus.FpOpOut), 0);
  endtask

  bit acc;
  int last;

  initial begin
    bus.FpValidE = 1'b0;
    bus.FpOpE    = 3'b000;
    bus.RdE      = 5'd0;
    bus.FlushE   = 1'b0;
    bus.UnitDone = 1'b0;

    //          op      rd     flush udAt doneAt err   ill
    vecs[0]  = '{3'd0, 5'd5,  1'b0, -1,  4,  1'b0, 1'b0}; // ADD
    vecs[1]  = '{3'd1, 5'd1,  1'b0, -1,  4,  1'b0, 1'b0}; // SUB
    vecs[2]  = '{3'd2, 5'd9,  1'b0, -1,  5,  1'b0, 1'b0}; // MUL
    vecs[3]  = '{3'd5, 5'd31, 1'b0, -1,  4,  1'b0, 1'b0}; // CVT
    vecs[4]  = '{3'd6, 5'd0,  1'b0, -1,  4,  1'b0, 1'b0}; // CMP
    vecs[5]  = '{3'd3, 5'd12, 1'b0, 10, 11,  1'b0, 1'b0}; // DIV, done at 10
    vecs[6]  = '{3'd3, 5'd20, 1'b0,  1,  2,  1'b0, 1'b0}; // DIV, done with FpStart
    vecs[7]  = '{3'd4, 5'd17, 1'b0, -1, 65,  1'b1, 1'b0}; // SQRT timeout
    vecs[8]  = '{3'd4, 5'd4,  1'b0, 64, 65,  1'b0, 1'b0}; // SQRT done on timeout cycle
    vecs[9]  = '{3'd0, 5'd6,  1'b1, -1,  0,  1'b0, 1'b0}; // flushed ADD
    vecs[10] = '{3'd7, 5'd3,  1'b0, -1,  0,  1'b0, 1'b1}; // reserved
    vecs[11] = '{3'd7, 5'd8,  1'b1, -1,  0,  1'b0, 1'b0}; // flushed reserved

    #1;
    checkAllZero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick;
    checkAllZero("post_reset");

    for (int i = 0; i < 12; i++) begin
      acc  = (vecs[i].op != 3'd7) && !vecs[i].flush;
      last = (vecs[i].doneAt > 0) ? vecs[i].doneAt + 1 : 3;
      bus.FpValidE = 1'b1;
      bus.FpOpE    = vecs[i].op;
      bus.RdE      = vecs[i].rd;
      bus.FlushE   = vecs[i].flush;
      #1;
      chk($sformatf("v%0d_busy_c0", i), int'(bus.BusyF), int'(acc));
      if (acc) sb.push_back('{vecs[i].op, vecs[i].rd, !vecs[i].err, vecs[i].err});
      tick;
      bus.FpValidE = 1'b0;
      bus.FlushE   = 1'b0;
      for (int c = 1; c <= last; c++) begin
        bus.UnitDone = (c == vecs[i].udAt);
        #1;
        chk($sformatf("v%0d_start_c%0d", i, c), int'(bus.FpStart), int'(acc && c == 1));
        chk($sformatf("v%0d_busy_c%0d", i, c), int'(bus.BusyF), int'(acc && c < vecs[i].doneAt));
        chk($sformatf("v%0d_done_c%0d", i, c), int'(bus.DoneF), int'(acc && c == vecs[i].doneAt));
        chk($sformatf("v%0d_ill_c%0d", i, c), int'(bus.IllegalF), int'(vecs[i].ill && c == 1));
        if (bus.DoneF) checkDone($sformatf("v%0d", i));
        tick;
      end
      bus.UnitDone = 1'b0;
    end
    chk("table_sb_empty", sb.size(), 0);

    // Back-to-back: MUL rd=3 completes at cycle 5 while ADD rd=7 issues.
    for (int c = 0; c <= 10; c++) begin
      bus.FpValidE = (c == 0) || (c == 5);
      bus.FpOpE    = (c == 0) ? 3'd2 : 3'd0;
      bus.RdE      = (c == 0) ? 5'd3 : 5'd7;
      #1;
      if (c == 0) sb.push_back('{3'd2, 5'd3, 1'b1, 1'b0});
      if (c == 5) sb.push_back('{3'd0, 5'd7, 1'b1, 1'b0});
      chk($sformatf("b2b_busy_c%0d", c), int'(bus.BusyF), int'(c <= 8));
      chk($sformatf("b2b_start_c%0d", c), int'(bus.FpStart), int'(c == 1 || c == 6));
      chk($sformatf("b2b_done_c%0d", c), int'(bus.DoneF), int'(c == 5 || c == 9));
      if (c >= 1) chk($sformatf("b2b_rdf_c%0d", c), int'(bus.RdF), (c >= 6) ? 7 : 3);
      if (bus.DoneF) checkDone($sformatf("b2b_c%0d", c));
      tick;
    end
    bus.FpValidE = 1'b0;
    chk("b2b_sb_empty", sb.size(), 0);

    // Reset in cycle 2 of a MUL aborts silently.
    bus.FpValidE = 1'b1;
    bus.FpOpE    = 3'd2;
    bus.RdE      = 5'd9;
    tick;
    bus.FpValidE = 1'b0;
    tick;
    chk("rst_busy_before", int'(bus.BusyF), 1);
    rst_n = 1'b0;
    #1;
    checkAllZero("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick;
    for (int c = 0; c < 8; c++) begin
      bus.UnitDone = (c == 1);
      #1;
      chk($sformatf("rst_after_done_c%0d", c), int'(bus.DoneF), 0);
      chk($sformatf("rst_after_busy_c%0d", c), int'(bus.BusyF), 0);
      chk($sformatf("rst_after_err_c%0d", c), int'(bus.ErrorF), 0);
      tick;
    end
    bus.UnitDone = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_op_sequencer.md
Name: fp_op_sequencer

Overview:
Sequences multi-cycle floating-point operations issued from the Execute stage. It accepts an FP op, latches its operands' control (opcode, destination register) and drives start/op to the FP datapath. It tracks fixed or variable completion and generates the BusyF/DoneF pair that the hazard unit consumes to stall Fetch/Decode. It also publishes the in-flight destination register and write enable for writeback and forwarding qualification.

Parameters:
LAT_ADD, 3, cycles for ADD/SUB/CVT/CMP (≥1)
LAT_MUL, 4, cycles for MUL (≥1)
TIMEOUT, 64, max WAIT cycles for DIV/SQRT before abort (≥2)
CNT_W, 7, counter width; must hold max(LAT_ADD, LAT_MUL, TIMEOUT)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
FpValidE  in  1  FP instruction present in Execute
FpOpE  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 SQRT, 101 CVT, 110 CMP, 111 reserved
RdE  in  5  destination register of Execute instruction
FlushE  in  1  Execute flush this cycle
UnitDone  in  1  variable-latency (DIV/SQRT) completion from FP datapath
FpStart  out  1  one-cycle start pulse to FP datapath
FpOpOut  out  3  latched opcode to FP datapath
RdF  out  5  latched destination register
BusyF  out  1  stall request to hazard unit
DoneF  out  1  one-cycle completion pulse
RegWriteF  out  1  write-enable for RdF, valid with DoneF
ErrorF  out  1  one-cycle pulse on DIV/SQRT timeout
IllegalF  out  1  one-cycle pulse on reserved opcode

Behaviour:
- Reset: async, rst_n=0 -> state IDLE; counter 0; FpStart, BusyF, DoneF, RegWriteF, ErrorF, IllegalF = 0; FpOpOut, RdF = 0. Reset mid-operation aborts silently: no DoneF, no ErrorF. UnitDone arriving after reset is ignored.
- States: IDLE, EXEC (fixed latency), WAIT (variable latency), DONE.
- accept = FpValidE & ~FlushE & (state==IDLE | state==DONE) & FpOpE!=111.
- Reserved op: FpValidE & ~FlushE & FpOpE==111 in IDLE/DONE -> IllegalF=1 next cycle, state -> IDLE, no BusyF.
- On accept (cycle 0):
  - latch FpOpOut, RdF.
  - Fixed ops: counter <- LAT, next state EXEC.
  - DIV/SQRT: counter <- 0, next state WAIT.
  - FpStart=1 in cycle 1 only.
- BusyF is combinational: accept | state==EXEC | state==WAIT. It is high in the accept cycle so the front end stalls immediately.
- EXEC: if counter==1 -> DONE, else counter--. EXEC occupies cycles 1..LAT; DoneF in cycle LAT+1.
- WAIT (entered cycle 1; UnitDone honoured from cycle 1, including the FpStart cycle):
  - UnitDone=1 -> DONE next cycle.
  - Else counter++. Counter reaching TIMEOUT -> DONE with abort flag set.
  - UnitDone in the same cycle as the timeout hit: UnitDone wins, no abort.
- DONE (one cycle):
  - DoneF=1; BusyF=0 unless a new accept occurs.
  - RegWriteF=1 except on abort (RegWriteF=0, ErrorF=1).
  - Next state: EXEC/WAIT on new accept (back-to-back, new FpStart next cycle), else IDLE.
- FpOpOut/RdF hold from the accept edge until the next accept. They must not change while BusyF=1.
- FlushE with FpValidE: no accept, no pulses. FlushE ignored while EXEC/WAIT; an in-flight op always completes.
- FpValidE while EXEC/WAIT: ignored (front end is stalled by BusyF; the same instruction re-presents if still in Execute).
- UnitDone in IDLE/EXEC/DONE: ignored.
- All pulse outputs are registered except BusyF.

Test Plan:
- ADD, rd=5, accept at cycle 0, LAT_ADD=3 -> BusyF=1 cycles 0-3; FpStart cycle 1; DoneF=1, RegWriteF=1, RdF=5 at cycle 4; BusyF=0 at cycle 4.
- DIV, rd=12, UnitDone pulsed at cycle 10 -> BusyF=1 cycles 0-10; DoneF at cycle 11 with RegWriteF=1; counter never aborts.
- SQRT with UnitDone never asserted, TIMEOUT=64 -> DoneF and ErrorF at cycle 65, RegWriteF=0; next cycle IDLE, BusyF=0.
- MUL completes (DoneF cycle 5) with a second FpValidE=1 ADD, rd=7, in cycle 5 -> back-to-back accept; FpStart cycle 6; RdF=7 from cycle 6; DoneF cycle 9.
- FpValidE=1 with FlushE=1 -> no BusyF, no FpStart. FpOpE=111 with FlushE=0 -> IllegalF one cycle, BusyF stays 0.
- rst_n low at cycle 2 of a MUL -> all outputs 0 asynchronously; no DoneF afterwards; stray UnitDone after release ignored.
